// File: rtl/lsb_mem_requester_pkg.sv
// rtl/lsb_mem_requester_pkg.sv - op codes, region constants and FSM state type shared by the LSB requester
package lsb_mem_requester_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam int ADDR_RANGE = 32;
    localparam int OP_W       = 6;

    localparam logic [OP_W-1:0] OP_LB  = 6'd1;
    localparam logic [OP_W-1:0] OP_LH  = 6'd2;
    localparam logic [OP_W-1:0] OP_LW  = 6'd3;
    localparam logic [OP_W-1:0] OP_LBU = 6'd4;
    localparam logic [OP_W-1:0] OP_LHU = 6'd5;
    localparam logic [OP_W-1:0] OP_SB  = 6'd6;
    localparam logic [OP_W-1:0] OP_SH  = 6'd7;
    localparam logic [OP_W-1:0] OP_SW  = 6'd8;

    // addr[17:16] selecting the memory-mapped IO window
    localparam logic [1:0] MMIO_REGION = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_LOAD  = 2'd1,
        ST_WAIT_STORE = 2'd2
    } req_state_e;

    function automatic logic is_mmio(input logic [ADDR_RANGE-1:0] addr);
        return addr[17:16] == MMIO_REGION;
    endfunction

endpackage

// File: rtl/lsb_mem_requester_load_extender.sv
// rtl/lsb_mem_requester_load_extender.sv - sign/zero extension of raw controller load data by op type
module lsb_mem_requester_load_extender
    import lsb_mem_requester_pkg::*;
(
    input  logic [OP_W-1:0] op,
    input  logic [31:0]     raw,
    output logic [31:0]     data
);

    always_comb begin
        data = raw;
        case (op)
            OP_LB:   data = {{24{raw[7]}}, raw[7:0]};
            OP_LBU:  data = {24'd0, raw[7:0]};
            OP_LH:   data = {{16{raw[15]}}, raw[15:0]};
            OP_LHU:  data = {16'd0, raw[15:0]};
            default: data = raw;
        endcase
    end

endmodule

// File: rtl/lsb_mem_requester.sv
// rtl/lsb_mem_requester.sv - in-order LSB queue issuing one load/store at a time to the memory controller; optional MMIO_GUARD_EN
module lsb_mem_requester
    import lsb_mem_requester_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int TAG_W = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  roll_back,
    input  logic                  enq_valid,
    input  logic                  enq_is_store,
    input  logic [OP_W-1:0]       enq_op,
    input  logic [ADDR_RANGE-1:0] enq_addr,
    input  logic [31:0]           enq_data,
    input  logic [TAG_W-1:0]      enq_tag,
    output logic                  full,
    input  logic                  commit_valid,
    input  logic [TAG_W-1:0]      commit_tag,
    input  logic                  io_buffer_full,
    output logic                  lsb_load,
    output logic [ADDR_RANGE-1:0] load_address,
    output logic [OP_W-1:0]       op_type_load,
    input  logic                  finished_load,
    input  logic [31:0]           get_load_data,
    output logic                  lsb_store,
    output logic [ADDR_RANGE-1:0] store_address,
    output logic [OP_W-1:0]       op_type_store,
    output logic [31:0]           get_store_data,
    input  logic                  finished_store,
    output logic                  result_valid,
    output logic [TAG_W-1:0]      result_tag,
    output logic [31:0]           result_data,
    output logic                  empty
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PTR_W = IDX_W + 1;

    logic [PTR_W-1:0]      head_q, tail_q, count;
    logic [IDX_W-1:0]      head_idx, tail_idx;
    logic [DEPTH-1:0]      ent_valid_q, ent_commit_q, ent_store_q;
    logic [OP_W-1:0]       ent_op_q   [DEPTH];
    logic [ADDR_RANGE-1:0] ent_addr_q [DEPTH];
    logic [31:0]           ent_data_q [DEPTH];
    logic [TAG_W-1:0]      ent_tag_q  [DEPTH];

    req_state_e            state_q, state_d;
    logic                  head_valid, head_store, head_commit;
    logic                  load_ok, store_ok, enq_fire, pop;
    logic [DEPTH-1:0]      commit_elig;
    logic [31:0]           ext_data;

    logic                  lsb_load_d, lsb_store_d, result_valid_d;
    logic [ADDR_RANGE-1:0] load_address_d, store_address_d;
    logic [OP_W-1:0]       op_type_load_d, op_type_store_d;
    logic [31:0]           store_data_d, result_data_d;
    logic [TAG_W-1:0]      result_tag_d;

    logic [DEPTH-1:0]      rb_valid;
    logic [PTR_W-1:0]      rb_count;
    logic [IDX_W-1:0]      rb_idx;
    logic                  rb_run;

    assign head_idx    = head_q[IDX_W-1:0];
    assign tail_idx    = tail_q[IDX_W-1:0];
    assign count       = tail_q - head_q;
    assign full        = (count == PTR_W'(DEPTH));
    assign empty       = (count == '0);
    assign enq_fire    = enq_valid && !full && !roll_back;
    assign head_valid  = ent_valid_q[head_idx];
    assign head_store  = ent_store_q[head_idx];
    assign head_commit = ent_commit_q[head_idx];

`ifdef MMIO_GUARD_EN
    logic head_mmio;
    assign head_mmio = is_mmio(ent_addr_q[head_idx]);
    // IO reads have side effects, so they wait for ROB commit like stores
    assign load_ok   = !head_mmio || head_commit;
    assign store_ok  = head_commit && !(head_mmio && io_buffer_full);

    always_comb begin
        commit_elig = '0;
        for (int i = 0; i < DEPTH; i++) begin
            commit_elig[i] = ent_store_q[i] || is_mmio(ent_addr_q[i]);
        end
    end
`else
    logic unused_io_buffer_full;
    assign unused_io_buffer_full = io_buffer_full;
    assign load_ok     = TRUE;
    assign store_ok    = head_commit;
    assign commit_elig = ent_store_q;
`endif

    lsb_mem_requester_load_extender u_load_extender (
        .op   (ent_op_q[head_idx]),
        .raw  (get_load_data),
        .data (ext_data)
    );

    // Committed entries form an unbroken run from head; roll_back keeps exactly that run.
    always_comb begin
        rb_valid = '0;
        rb_count = '0;
        rb_run   = TRUE;
        rb_idx   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            rb_idx = head_idx + IDX_W'(k);
            if (rb_run && ent_valid_q[rb_idx] && ent_commit_q[rb_idx]) begin
                rb_valid[rb_idx] = TRUE;
                rb_count         = rb_count + PTR_W'(1);
            end else begin
                rb_run = FALSE;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            head_q       <= '0;
            tail_q       <= '0;
            ent_valid_q  <= '0;
            ent_commit_q <= '0;
        end else if (rdy_in) begin
            if (roll_back) begin
                tail_q       <= head_q + rb_count;
                ent_valid_q  <= rb_valid;
                ent_commit_q <= rb_valid;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (commit_valid && ent_valid_q[i] && commit_elig[i] &&
                        ent_tag_q[i] == commit_tag) begin
                        ent_commit_q[i] <= TRUE;
                    end
                end
                if (enq_fire) begin
                    ent_valid_q[tail_idx]  <= TRUE;
                    ent_commit_q[tail_idx] <= FALSE;
                    tail_q                 <= tail_q + PTR_W'(1);
                end
                if (pop) begin
                    ent_valid_q[head_idx]  <= FALSE;
                    ent_commit_q[head_idx] <= FALSE;
                    head_q                 <= head_q + PTR_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rdy_in && enq_fire) begin
            ent_store_q[tail_idx] <= enq_is_store;
            ent_op_q[tail_idx]    <= enq_op;
            ent_addr_q[tail_idx]  <= enq_addr;
            ent_data_q[tail_idx]  <= enq_data;
            ent_tag_q[tail_idx]   <= enq_tag;
        end
    end

    // Requests are launched only from IDLE, so a finish cycle is always followed by one idle cycle.
    always_comb begin
        state_d         = state_q;
        lsb_load_d      = lsb_load;
        load_address_d  = load_address;
        op_type_load_d  = op_type_load;
        lsb_store_d     = lsb_store;
        store_address_d = store_address;
        op_type_store_d = op_type_store;
        store_data_d    = get_store_data;
        result_valid_d  = FALSE;
        result_tag_d    = result_tag;
        result_data_d   = result_data;
        pop             = FALSE;

        case (state_q)
            ST_IDLE: begin
                if (head_valid && !head_store && load_ok) begin
                    lsb_load_d     = TRUE;
                    load_address_d = ent_addr_q[head_idx];
                    op_type_load_d = ent_op_q[head_idx];
                    state_d        = ST_WAIT_LOAD;
                end else if (head_valid && head_store && store_ok) begin
                    lsb_store_d     = TRUE;
                    store_address_d = ent_addr_q[head_idx];
                    op_type_store_d = ent_op_q[head_idx];
                    store_data_d    = ent_data_q[head_idx];
                    state_d         = ST_WAIT_STORE;
                end
            end
            ST_WAIT_LOAD: begin
                if (finished_load) begin
                    lsb_load_d     = FALSE;
                    result_valid_d = TRUE;
                    result_tag_d   = ent_tag_q[head_idx];
                    result_data_d  = ext_data;
                    pop            = TRUE;
                    state_d        = ST_IDLE;
                end
            end
            ST_WAIT_STORE: begin
                if (finished_store) begin
                    lsb_store_d = FALSE;
                    pop         = TRUE;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (roll_back) begin
            state_d        = ST_IDLE;
            lsb_load_d     = FALSE;
            lsb_store_d    = FALSE;
            result_valid_d = FALSE;
            pop            = FALSE;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q        <= ST_IDLE;
            lsb_load       <= FALSE;
            load_address   <= '0;
            op_type_load   <= '0;
            lsb_store      <= FALSE;
            store_address  <= '0;
            op_type_store  <= '0;
            get_store_data <= '0;
            result_valid   <= FALSE;
            result_tag     <= '0;
            result_data    <= '0;
        end else if (rdy_in) begin
            state_q        <= state_d;
            lsb_load       <= lsb_load_d;
            load_address   <= load_address_d;
            op_type_load   <= op_type_load_d;
            lsb_store      <= lsb_store_d;
            store_address  <= store_address_d;
            op_type_store  <= op_type_store_d;
            get_store_data <= store_data_d;
            result_valid   <= result_valid_d;
            result_tag     <= result_tag_d;
            result_data    <= result_data_d;
        end
    end

endmodule
